cond_flag_unit: RTL and testbench

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

---
 rtl/cond_flag_unit_pkg.sv | 49 ++++
 rtl/cond_eval.sv | 49 ++++
 rtl/cond_flag_unit.sv | 105 ++++++++++
 tb/tb_cond_flag_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_flag_unit_pkg.sv
// cond_flag_unit_pkg
// Shared definitions for the condition/flag unit:
//   - cond_e   : 4-bit condition codes EQ..NV
//   - FLAG_*   : bit positions of N, Z, V and C inside a flags_t word
//   - flags_t  : 4-bit flag word laid out as {N,Z,V,C}
//   - calc_flags : flags produced by the subtraction a - b
package cond_flag_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef logic [3:0] flags_t;

  // Flags of a - b. The subtraction is done 17 bits wide so bit 16 is the
  // borrow; C is its inverse (set when a >= b unsigned).
  function automatic flags_t calc_flags(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] diff;
    flags_t      f;
    diff      = {1'b0, a} - {1'b0, b};
    f         = 4'b0000;
    f[FLAG_N] = diff[15];
    f[FLAG_Z] = (diff[15:0] == 16'h0000);
    f[FLAG_V] = (a[15] != b[15]) && (diff[15] != a[15]);
    f[FLAG_C] = ~diff[16];
    return f;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval
// Purely combinational condition decoder.
// Ports:
//   cond  (in, 4) : condition code (cond_e encoding)
//   flags (in, 4) : flag word {N,Z,V,C} to test
//   take  (out,1) : 1 when the condition holds for the given flags
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       take
);

  logic n;
  logic z;
  logic v;
  logic c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  // Map each condition code onto its flag expression.
  always_comb begin
    take = 1'b0;
    case (cond_e'(cond))
      COND_EQ: take = z;
      COND_NE: take = ~z;
      COND_HS: take = c;
      COND_LO: take = ~c;
      COND_MI: take = n;
      COND_PL: take = ~n;
      COND_VS: take = v;
      COND_VC: take = ~v;
      COND_HI: take = c & ~z;
      COND_LS: take = ~c | z;
      COND_GE: take = (n == v);
      COND_LT: take = (n != v);
      COND_GT: take = ~z & (n == v);
      COND_LE: take = z | (n != v);
      COND_AL: take = 1'b1;
      COND_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
// Two-stage in-order pipeline that either computes flags from a - b and
// stores them (setf=1) or tests a condition against the stored flags (setf=0).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake
//   in_a, in_b (16)     : minuend / subtrahend
//   in_cond (4)         : condition code to evaluate
//   in_setf             : 1 = compute and store new flags, 0 = use stored flags
//   out_valid/out_ready : output handshake
//   out_take            : condition result
//   out_flags (4)       : flags the condition was evaluated against, {N,Z,V,C}
module cond_flag_unit
  import cond_flag_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [3:0]  in_cond,
  input  logic        in_setf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_take,
  output logic [3:0]  out_flags
);

  logic        s1_valid;
  logic [15:0] s1_a;
  logic [15:0] s1_b;
  logic [3:0]  s1_cond;
  logic        s1_setf;
  flags_t      flag_reg;

  logic        s2_adv;
  logic        s1_adv;
  flags_t      new_flags;
  flags_t      eval_flags;
  logic        eval_take;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  // Held low while reset is asserted so nothing is accepted into a stage
  // that is being cleared.
  assign in_ready = ~rst & s1_adv;

  // Choose freshly computed flags or the stored flag register. Because the
  // flag register is written only as a transaction leaves S1, it already
  // reflects every older setf transaction here.
  always_comb begin
    new_flags = calc_flags(s1_a, s1_b);
    if (s1_setf) begin
      eval_flags = new_flags;
    end else begin
      eval_flags = flag_reg;
    end
  end

  cond_eval u_cond_eval (
    .cond  (s1_cond),
    .flags (eval_flags),
    .take  (eval_take)
  );

  // Stage 1: capture the accepted transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= 16'h0000;
      s1_b     <= 16'h0000;
      s1_cond  <= 4'h0;
      s1_setf  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_cond <= in_cond;
        s1_setf <= in_setf;
      end
    end
  end

  // Stage 2: register the evaluated result and commit new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_take  <= 1'b0;
      out_flags <= 4'b0000;
      flag_reg  <= 4'b0000;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_take  <= eval_take;
        out_flags <= eval_flags;
        if (s1_setf) begin
          flag_reg <= new_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit
// Scoreboard bench: the driver pushes the reference result of every accepted
// transaction into a queue; an independent monitor pops and compares each
// time the DUT hands over a result. Directed cases pin down latency,
// backpressure and reset, followed by randomized traffic with random
// out_ready.
module tb_cond_flag_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_cond;
  logic        in_setf;
  logic        out_valid;
  logic        out_ready;
  logic        out_take;
  logic [3:0]  out_flags;

  cond_flag_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cond   (in_cond),
    .in_setf   (in_setf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_take  (out_take),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          passes = 0;
  int          total  = 0;
  logic [4:0]  exp_q[$];
  logic [3:0]  model_f = 4'b0000;
  int          bp_mode = 0;   // 0: out_ready high, 1: random, 2: driven by main
  logic        held_valid = 1'b0;
  logic [4:0]  held_val;
  logic [4:0]  popped;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference flags from integer arithmetic on the operand values.
  function automatic logic [3:0] ref_flags(input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, d, sd;
    logic n, z, v, c;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    d  = ua - ub;
    sd = sa - sb;
    n  = (((d + 65536) % 65536) >= 32768);
    z  = (ua == ub);
    c  = (ua >= ub);
    v  = (sd > 32767) || (sd < -32768);
    return {n, z, v, c};
  endfunction

  function automatic logic ref_take(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fv, fc;
    {fn, fz, fv, fc} = f;
    case (cc)
      4'd0:    return fz;
      4'd1:    return !fz;
      4'd2:    return fc;
      4'd3:    return !fc;
      4'd4:    return fn;
      4'd5:    return !fn;
      4'd6:    return fv;
      4'd7:    return !fv;
      4'd8:    return fc && !fz;
      4'd9:    return !fc || fz;
      4'd10:   return fn == fv;
      4'd11:   return fn != fv;
      4'd12:   return !fz && (fn == fv);
      4'd13:   return fz || (fn != fv);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Offer one transaction, wait (bounded) for acceptance, record expectation.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] cc, input logic s);
    int waited;
    logic [3:0] f;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cond = cc; in_setf = s;
    #1;
    while (!in_ready && waited < 60) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 16'd0, 16'd1);
      in_valid = 1'b0;
    end else begin
      f = s ? ref_flags(a, b) : model_f;
      if (s) model_f = f;
      exp_q.push_back({ref_take(cc, f), f});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #4;
    end
    check("drain_empty", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Backpressure generator.
  always @(negedge clk) begin
    if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (bp_mode == 0) out_ready = 1'b1;
  end

  // Monitor: compare each handed-over result, and check that a stalled
  // result does not change.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      held_valid = 1'b0;
    end else if (out_valid) begin
      if (held_valid) check("stall_stable", {11'd0, out_take, out_flags}, {11'd0, held_val});
      if (!out_ready) begin
        held_valid = 1'b1;
        held_val   = {out_take, out_flags};
      end else begin
        held_valid = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 16'd1, 16'd0);
        end else begin
          popped = exp_q.pop_front();
          check("sb_take", {15'd0, out_take}, {15'd0, popped[4]});
          check("sb_flags", {12'd0, out_flags}, {12'd0, popped[3:0]});
        end
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
    in_cond = 4'h0; in_setf = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_flags", {12'd0, out_flags}, 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

    // 0x8000 - 0x0001, HI: two-cycle latency
    issue(16'h8000, 16'h0001, 4'h8, 1'b1);
    check("lat_early_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    check("lat_valid", {15'd0, out_valid}, 16'd1);
    check("hi_flags", {12'd0, out_flags}, 16'h3);
    check("hi_take", {15'd0, out_take}, 16'd1);

    // equal operands then stored-flag evaluation
    issue(16'h1234, 16'h1234, 4'h0, 1'b1);
    issue(16'($urandom), 16'($urandom), 4'h3, 1'b0);
    check("eq_flags", {12'd0, out_flags}, 16'h5);
    check("eq_take", {15'd0, out_take}, 16'd1);
    @(posedge clk); #1;
    check("lo_stored_flags", {12'd0, out_flags}, 16'h5);
    check("lo_stored_take", {15'd0, out_take}, 16'd0);

    // 0 - 1 with LT and LO
    issue(16'h0000, 16'h0001, 4'hB, 1'b1);
    @(posedge clk); #1;
    check("lt_flags", {12'd0, out_flags}, 16'h8);
    check("lt_take", {15'd0, out_take}, 16'd1);
    issue(16'h0000, 16'h0001, 4'h3, 1'b1);
    @(posedge clk); #1;
    check("lo_take", {15'd0, out_take}, 16'd1);

    // NV / AL
    for (int i = 0; i < 4; i++) begin
      issue(pick(), pick(), 4'hF, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      check("nv_take", {15'd0, out_take}, 16'd0);
      issue(pick(), pick(), 4'hE, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      check("al_take", {15'd0, out_take}, 16'd1);
    end

    // backpressure: two held, third waits
    drain();
    bp_mode = 2; out_ready = 1'b0;
    issue(16'h0005, 16'h0003, 4'h8, 1'b1);
    issue(16'h0003, 16'h0005, 4'h3, 1'b1);
    check("bp_full_in_ready", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("bp_hold_in_ready", {15'd0, in_ready}, 16'd0);
    end
    bp_mode = 0; out_ready = 1'b1;
    issue(16'h0000, 16'h0000, 4'h0, 1'b0);
    drain();

    // reset with both stages full
    bp_mode = 2; out_ready = 1'b0;
    issue(16'h0000, 16'h0001, 4'h4, 1'b1);
    issue(16'h8000, 16'h0001, 4'h6, 1'b1);
    check("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    @(negedge clk);
    rst = 1'b1; exp_q.delete(); model_f = 4'b0000;
    #1;
    check("rst_cycle_in_ready", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_clr_valid", {15'd0, out_valid}, 16'd0);
    check("rst_clr_take", {15'd0, out_take}, 16'd0);
    check("rst_clr_flags", {12'd0, out_flags}, 16'd0);
    bp_mode = 0; out_ready = 1'b1;
    issue(16'($urandom), 16'($urandom), 4'h0, 1'b0);
    @(posedge clk); #1;
    check("rst_f_valid", {15'd0, out_valid}, 16'd1);
    check("rst_f_take", {15'd0, out_take}, 16'd0);
    check("rst_f_flags", {12'd0, out_flags}, 16'd0);

    // randomized traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick();
      issue(ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    bp_mode = 0;
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
